spirxdata: RTL and testbench
============================

SPIRXDATA -- requirements
Module: spirxdata

Interface
REQ-001 The block SHALL have parameter DW, default 32, memory word width in bits (fixed at 32).
REQ-002 The block SHALL have parameter AW, default 8, memory address width; the MSB is the buffer-select bit.
REQ-003 The block SHALL have parameter LGTIMEOUT, default 8, log2 of the maximum count of 0xFF bytes allowed while waiting for the start token.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_start, input, 1 bit: request to receive one data block; ignored while o_busy is high.
REQ-007 The block SHALL have port i_lgblksz, input, 4 bits: log2 of the block size in bytes.
REQ-008 The block SHALL have port i_fifo, input, 1 bit: selects the destination buffer.
REQ-009 The block SHALL have port o_busy, output, 1 bit: transfer in progress.
REQ-010 The block SHALL have port o_ll_stb, output, 1 bit: request to clock one byte from the low-level SPI engine.
REQ-011 The block SHALL have port o_ll_byte, output, 8 bits: byte transmitted, constant 8'hff.
REQ-012 The block SHALL have port i_ll_busy, input, 1 bit: low-level engine busy; a request is accepted when o_ll_stb && !i_ll_busy.
REQ-013 The block SHALL have ports i_ll_stb, input, 1 bit, and i_ll_byte, input, 8 bits: a received byte and its valid strobe.
REQ-014 The block SHALL have ports o_write, output, 1 bit; o_addr, output, AW bits; o_data, output, DW bits: memory write strobe, address and data.
REQ-015 The block SHALL have ports o_done, output, 1 bit; o_err, output, 1 bit; o_crcerr, output, 1 bit; o_timeout, output, 1 bit; o_response, output, 8 bits: completion pulse, status flags and the captured error token.

Function
REQ-016 The state machine SHALL have states IDLE, TOKEN, DATA, CRC1, CRC0; in IDLE, i_start SHALL latch i_lgblksz (clamped to 3..9), set o_addr={i_fifo,0}, clear o_err/o_crcerr/o_timeout, set o_busy, and enter TOKEN.
REQ-017 Byte flow SHALL allow at most one request outstanding: raise o_ll_stb, hold it until accepted, drop it, wait for i_ll_stb, then re-issue if the state still needs bytes.
REQ-018 In TOKEN: byte 8'hff SHALL increment the timeout counter; 8'hfe SHALL enter DATA; a byte with [7:4]==0 SHALL set o_err, capture o_response, and finish; any other byte SHALL be ignored.
REQ-019 When the timeout count reaches 2^LGTIMEOUT, the block SHALL set o_timeout and finish.
REQ-020 In DATA, bytes SHALL pack big-endian (first byte into o_data[31:24]); the cycle after the 4th byte's i_ll_stb, o_write SHALL pulse for exactly one cycle.
REQ-021 o_addr[AW-2:0] SHALL increment after each write; DATA SHALL end after 2^(lgblksz-2) words, then enter CRC1, CRC0.
REQ-022 Finish: the cycle after the terminating byte, o_done SHALL pulse for one cycle and o_busy SHALL fall; status flags SHALL hold until the next i_start.
REQ-023 i_ll_stb in IDLE, or with no request outstanding, SHALL be ignored.

Reset
REQ-024 Assertion of i_reset_n low SHALL immediately force IDLE, all strobes low, o_busy/o_err/o_crcerr/o_timeout low, and o_addr/o_data/o_response/counters to 0, including mid-transfer; the first request after release SHALL require a new i_start.

Configuration
REQ-025 With SPIRXDATA_CRC_EN defined, a CRC-16 (poly 0x1021, init 0, MSB-first) SHALL run over data bytes, and o_crcerr SHALL be set at finish if it mismatches the received {CRC1,CRC0}; without the macro, the CRC bytes SHALL still be clocked and discarded, and o_crcerr SHALL be tied to 0.

Verification
REQ-026 Scenario: lgblksz=3, i_fifo=0, bytes FF FF FE 01..08 plus a valid CRC -> writes (0x00, 0x01020304) then (0x01, 0x05060708), o_done pulse, all flags 0.
REQ-027 Scenario: lgblksz=4, i_fifo=1 -> exactly 4 writes, at addresses 0x80,0x81,0x82,0x83.
REQ-028 Scenario: token byte 0x05 -> o_err=1, o_response=0x05, no o_write, o_done pulse.
REQ-029 Scenario: LGTIMEOUT=4 with only FF bytes -> o_timeout=1 after 16 bytes, o_done pulse, o_busy low.
REQ-030 Scenario: CRC low byte flipped -> o_crcerr=1 with SPIRXDATA_CRC_EN defined, o_crcerr=0 without it; writes are identical in both builds.
REQ-031 Scenario: i_reset_n low during DATA after 2 writes -> all outputs 0 immediately, no further writes, and the next i_start restarts at address 0.

Source files
------------

// File: rtl/spirxdata.sv
// spirxdata: receives one data block from an SPI/SD-card low-level byte engine.
//
// Purpose:
//   Clocks 0xFF bytes out of the low-level engine, waits for the 0xFE start token (with a
//   bounded count of idle 0xFF bytes), packs 2^lgblksz data bytes big-endian into 32-bit
//   memory words, then clocks and checks the two trailing CRC bytes.
//
// Optional feature (macro SPIRXDATA_CRC_EN):
//   defined   - CRC-16 (poly 0x1021, init 0, MSB first) over the data bytes; o_crcerr is set
//               at finish when it disagrees with the received {CRC1, CRC0}.
//   undefined - CRC bytes are clocked and discarded; o_crcerr is tied low.
//
// Ports:
//   i_clk, i_reset_n          clock (rising edge), asynchronous active-low reset
//   i_start, i_lgblksz        start request and log2 block size (clamped to 3..9)
//   i_fifo                    destination buffer (becomes o_addr MSB)
//   o_busy                    transfer in progress
//   o_ll_stb, o_ll_byte       byte request to the low-level engine (always sends 0xFF)
//   i_ll_busy                 engine busy; a request is taken when o_ll_stb && !i_ll_busy
//   i_ll_stb, i_ll_byte       received byte strobe and value
//   o_write, o_addr, o_data   memory write port
//   o_done                    one-cycle completion pulse
//   o_err, o_response         error token seen, and its value
//   o_crcerr, o_timeout       CRC mismatch, start token never arrived
module spirxdata #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 8,
    parameter int unsigned LGTIMEOUT = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [3:0]    i_lgblksz,
    input  logic          i_fifo,
    output logic          o_busy,
    output logic          o_ll_stb,
    output logic [7:0]    o_ll_byte,
    input  logic          i_ll_busy,
    input  logic          i_ll_stb,
    input  logic [7:0]    i_ll_byte,
    output logic          o_write,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_done,
    output logic          o_err,
    output logic          o_crcerr,
    output logic          o_timeout,
    output logic [7:0]    o_response
);

    typedef enum logic [2:0] {StIdle, StToken, StData, StCrc1, StCrc0} state_e;

    state_e               state_q, state_d;
    logic                 stb_q;     // request raised, not yet taken by the engine
    logic                 pend_q;    // request taken, waiting for the byte
    logic [3:0]           lg_q;
    logic [LGTIMEOUT-1:0] tcnt_q;
    logic [1:0]           bcnt_q;    // byte position within the current word
    logic [7:0]           wcnt_q;    // words completed
    logic [7:0]           last_word;
    logic                 rx_valid;
    logic                 start_go;

    function automatic logic [3:0] clamp_lg(input logic [3:0] lg);
        if (lg < 4'd3) return 4'd3;
        if (lg > 4'd9) return 4'd9;
        return lg;
    endfunction

    // Only a byte answering our own accepted request counts.
    assign rx_valid  = pend_q && i_ll_stb;
    assign start_go  = (state_q == StIdle) && i_start;
    assign last_word = (8'd1 << (lg_q - 4'd2)) - 8'd1;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= StIdle;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (i_start) state_d = StToken;
            StToken: begin
                if (rx_valid) begin
                    if (i_ll_byte == 8'hff) begin
                        if (&tcnt_q) state_d = StIdle;
                    end else if (i_ll_byte == 8'hfe) begin
                        state_d = StData;
                    end else if (i_ll_byte[7:4] == 4'h0) begin
                        state_d = StIdle;
                    end
                end
            end
            StData:  if (rx_valid && (&bcnt_q) && (wcnt_q == last_word)) state_d = StCrc1;
            StCrc1:  if (rx_valid) state_d = StCrc0;
            StCrc0:  if (rx_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs that follow directly from state
    always_comb begin
        o_busy    = (state_q != StIdle);
        o_ll_stb  = stb_q;
        o_ll_byte = 8'hff;
    end

    // Handshake, counters and datapath
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stb_q      <= 1'b0;
            pend_q     <= 1'b0;
            lg_q       <= 4'd0;
            tcnt_q     <= '0;
            bcnt_q     <= 2'd0;
            wcnt_q     <= 8'd0;
            o_write    <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_timeout  <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_response <= 8'd0;
        end else begin
            o_write <= 1'b0;
            o_done  <= (state_q != StIdle) && (state_d == StIdle);

            // Address advances once the write it addressed has been presented.
            if (o_write) o_addr[AW-2:0] <= o_addr[AW-2:0] + (AW-1)'(1);

            if (stb_q && !i_ll_busy) begin
                stb_q  <= 1'b0;
                pend_q <= 1'b1;
            end
            if (rx_valid) begin
                pend_q <= 1'b0;
                stb_q  <= (state_d != StIdle);
            end

            if (start_go) begin
                lg_q      <= clamp_lg(i_lgblksz);
                o_addr    <= {i_fifo, {(AW-1){1'b0}}};
                o_err     <= 1'b0;
                o_timeout <= 1'b0;
                tcnt_q    <= '0;
                bcnt_q    <= 2'd0;
                wcnt_q    <= 8'd0;
                stb_q     <= 1'b1;
            end

            if (rx_valid) begin
                case (state_q)
                    StToken: begin
                        if (i_ll_byte == 8'hff) begin
                            tcnt_q <= tcnt_q + LGTIMEOUT'(1);
                            if (&tcnt_q) o_timeout <= 1'b1;
                        end else if (i_ll_byte != 8'hfe && i_ll_byte[7:4] == 4'h0) begin
                            o_err      <= 1'b1;
                            o_response <= i_ll_byte;
                        end
                    end
                    StData: begin
                        o_data <= {o_data[DW-9:0], i_ll_byte};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (&bcnt_q) begin
                            o_write <= 1'b1;
                            wcnt_q  <= wcnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPIRXDATA_CRC_EN
    logic [15:0] crc_q;
    logic [7:0]  crc_hi_q;
    logic        crcerr_q;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc_q    <= 16'd0;
            crc_hi_q <= 8'd0;
            crcerr_q <= 1'b0;
        end else if (start_go) begin
            crc_q    <= 16'd0;
            crcerr_q <= 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                StData:  crc_q    <= crc16_byte(crc_q, i_ll_byte);
                StCrc1:  crc_hi_q <= i_ll_byte;
                StCrc0:  crcerr_q <= ({crc_hi_q, i_ll_byte} != crc_q);
                default: ;
            endcase
        end
    end

    assign o_crcerr = crcerr_q;
`else
    assign o_crcerr = 1'b0;
`endif

endmodule

// File: tb/tb_spirxdata.sv
module tb_spirxdata;

    localparam int TB_LGT = 4;
    localparam int TMO    = 1 << TB_LGT;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic [3:0]  i_lgblksz;
    logic        i_fifo;
    logic        o_busy;
    logic        o_ll_stb;
    logic [7:0]  o_ll_byte;
    logic        i_ll_busy;
    logic        i_ll_stb;
    logic [7:0]  i_ll_byte;
    logic        o_write;
    logic [7:0]  o_addr;
    logic [31:0] o_data;
    logic        o_done;
    logic        o_err;
    logic        o_crcerr;
    logic        o_timeout;
    logic [7:0]  o_response;

    spirxdata #(.DW(32), .AW(8), .LGTIMEOUT(TB_LGT)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (i_start),
        .i_lgblksz  (i_lgblksz),
        .i_fifo     (i_fifo),
        .o_busy     (o_busy),
        .o_ll_stb   (o_ll_stb),
        .o_ll_byte  (o_ll_byte),
        .i_ll_busy  (i_ll_busy),
        .i_ll_stb   (i_ll_stb),
        .i_ll_byte  (i_ll_byte),
        .o_write    (o_write),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_crcerr   (o_crcerr),
        .o_timeout  (o_timeout),
        .o_response (o_response)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]  stim[$];       // bytes the engine will return, in order
    logic [31:0] exp_words[$];
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          served = 0;
    int          stb_overlap = 0;
    int          wr_dbl = 0;
    bit          spur_en = 0;
    bit          m_err, m_to, m_crc;
    logic [7:0]  m_resp = 8'd0;
    int          m_consumed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // CRC-16 as the remainder of (message * x^16) / (x^16 + x^12 + x^5 + 1).
    function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
        logic [16:0] r;
        r = 17'd0;
        foreach (d[k]) begin
            for (int i = 7; i >= 0; i--) begin
                r = {r[15:0], d[k][i]};
                if (r[16]) r = r ^ 17'h11021;
            end
        end
        for (int i = 0; i < 16; i++) begin
            r = {r[15:0], 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    function automatic logic [7:0] stim_at(input int i);
        return (i < stim.size()) ? stim[i] : 8'hff;
    endfunction

    // Low-level engine: one request at a time, random busy and latency, optional
    // unsolicited strobes while nothing is outstanding.
    initial begin : engine
        bit eng_out;
        int eng_dly;
        eng_out = 0;
        eng_dly = 0;
        i_ll_busy = 1'b0;
        i_ll_stb  = 1'b0;
        i_ll_byte = 8'h00;
        forever begin
            @(negedge i_clk);
            i_ll_stb = 1'b0;
            if (eng_out) begin
                if (o_ll_stb) stb_overlap++;
                eng_dly--;
                if (eng_dly == 0) begin
                    i_ll_byte = (stim.size() > 0) ? stim.pop_front() : 8'hff;
                    i_ll_stb  = 1'b1;
                    i_ll_busy = 1'b0;
                    eng_out   = 0;
                    served++;
                end else begin
                    i_ll_busy = 1'b1;
                end
            end else begin
                i_ll_busy = ($urandom_range(0, 3) == 0);
                if (o_ll_stb && !i_ll_busy) begin
                    eng_out = 1;
                    eng_dly = $urandom_range(1, 3);
                end else if (spur_en && $urandom_range(0, 4) == 0) begin
                    i_ll_stb  = 1'b1;
                    i_ll_byte = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'hfe;
                end
            end
        end
    end

    always @(negedge i_clk) begin : wr_mon
        bit prev_wr;
        if (o_write) begin
            wr_addr.push_back(o_addr);
            wr_data.push_back(o_data);
            if (prev_wr) wr_dbl++;
        end
        prev_wr = o_write;
    end

    task automatic build_stim(input int nff, input logic [7:0] junk, input logic [7:0] tok,
                              input logic [3:0] lg_in, input bit rnd, input bit bad_crc);
        logic [7:0]  d[$];
        logic [7:0]  b;
        logic [15:0] c;
        int          lg;
        lg = (lg_in < 3) ? 3 : ((lg_in > 9) ? 9 : int'(lg_in));
        stim.delete();
        for (int i = 0; i < nff; i++) stim.push_back(8'hff);
        if (junk != 8'h00) stim.push_back(junk);
        stim.push_back(tok);
        for (int k = 0; k < (1 << lg); k++) begin
            b = rnd ? 8'($urandom) : 8'(k + 1);
            d.push_back(b);
            stim.push_back(b);
        end
        c = crc_ref(d);
        stim.push_back(c[15:8]);
        stim.push_back(bad_crc ? ~c[7:0] : c[7:0]);
    endtask

    // Reference: walk the byte stream by the token/data/CRC rules.
    task automatic model_run(input logic [3:0] lg_in);
        int          lg, idx, ffc;
        logic [7:0]  b;
        logic [7:0]  d[$];
        logic [15:0] rx;
        lg = (lg_in < 3) ? 3 : ((lg_in > 9) ? 9 : int'(lg_in));
        m_err = 0; m_to = 0; m_crc = 0;
        exp_words.delete();
        idx = 0; ffc = 0;
        forever begin
            b = stim_at(idx);
            idx++;
            if (b == 8'hff) begin
                ffc++;
                if (ffc == TMO) begin m_to = 1; m_consumed = idx; return; end
            end else if (b == 8'hfe) begin
                break;
            end else if (b[7:4] == 4'h0) begin
                m_err = 1; m_resp = b; m_consumed = idx; return;
            end
        end
        for (int k = 0; k < (1 << lg); k++) d.push_back(stim_at(idx + k));
        for (int w = 0; w < (1 << lg) / 4; w++)
            exp_words.push_back({d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]});
        idx += (1 << lg);
        rx = {stim_at(idx), stim_at(idx + 1)};
        m_consumed = idx + 2;
`ifdef SPIRXDATA_CRC_EN
        m_crc = (rx != crc_ref(d));
`else
        m_crc = (rx == 16'hxxxx);  // never true; CRC is not checked in this build
`endif
    endtask

    task automatic run_xfer(input logic [3:0] lg, input logic fifo, input bit poke,
                            output bit got_done);
        wr_addr.delete();
        wr_data.delete();
        served = 0;
        @(negedge i_clk);
        i_lgblksz = lg; i_fifo = fifo; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        got_done = 0;
        for (int c = 0; c < 8000 && !got_done; c++) begin
            if (o_done) begin
                got_done = 1;
            end else begin
                if (poke && c == 8 && o_busy) begin
                    i_start = 1'b1; i_fifo = ~fifo; i_lgblksz = 4'd9;
                end
                @(negedge i_clk);
                i_start = 1'b0;
            end
        end
    endtask

    task automatic compare_result(input string tag, input logic [7:0] base, input bit got_done,
                                  input bit e_err, input bit e_to, input bit e_crc,
                                  input logic [7:0] e_resp);
        check({tag, " done"}, 32'(got_done), 32'd1);
        check({tag, " nwrites"}, 32'(wr_addr.size()), 32'(exp_words.size()));
        for (int i = 0; i < wr_addr.size() && i < exp_words.size(); i++) begin
            check({tag, " addr"}, 32'(wr_addr[i]), 32'(8'(base + 8'(i))));
            check({tag, " data"}, wr_data[i], exp_words[i]);
        end
        check({tag, " err"}, 32'(o_err), 32'(e_err));
        check({tag, " timeout"}, 32'(o_timeout), 32'(e_to));
        check({tag, " crcerr"}, 32'(o_crcerr), 32'(e_crc));
        check({tag, " busy_at_done"}, 32'(o_busy), 32'd0);
        if (e_err) check({tag, " response"}, 32'(o_response), 32'(e_resp));
        @(negedge i_clk);
        check({tag, " done_width"}, 32'(o_done), 32'd0);
    endtask

    typedef struct {
        logic [3:0] lg;
        logic       fifo;
        int         nff;
        logic [7:0] junk;
        logic [7:0] tok;
        bit         bad_crc;
        int         exp_nw;
        logic [7:0] exp_base;
        bit         exp_err;
        bit         exp_to;
        logic [7:0] exp_resp;
        bit         exp_crc_en;   // o_crcerr expected when the CRC check is built in
    } vec_t;

    vec_t vecs[11];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         got;
        bit         e_crc;
        int         nwr, nstb, nbusy;
        logic [3:0] lg;
        logic       fifo;

        //            lg     f   nff junk   tok    bad nw   base   err to resp   crc
        vecs[0]  = '{4'd3,  0,  2, 8'h00, 8'hfe, 0,  2,  8'h00, 0, 0, 8'h00, 0};
        vecs[1]  = '{4'd4,  1,  0, 8'h00, 8'hfe, 0,  4,  8'h80, 0, 0, 8'h00, 0};
        vecs[2]  = '{4'd3,  0,  1, 8'h00, 8'h05, 0,  0,  8'h00, 1, 0, 8'h05, 0};
        vecs[3]  = '{4'd3,  0,  0, 8'h00, 8'h00, 0,  0,  8'h00, 1, 0, 8'h00, 0};
        vecs[4]  = '{4'd3,  1,  3, 8'h00, 8'h0f, 0,  0,  8'h80, 1, 0, 8'h0f, 0};
        vecs[5]  = '{4'd3,  0, 16, 8'h00, 8'hfe, 0,  0,  8'h00, 0, 1, 8'h00, 0};
        vecs[6]  = '{4'd3,  0, 15, 8'h80, 8'hfe, 0,  2,  8'h00, 0, 0, 8'h00, 0};
        vecs[7]  = '{4'd3,  0,  0, 8'h00, 8'hfe, 1,  2,  8'h00, 0, 0, 8'h00, 1};
        vecs[8]  = '{4'd2,  0,  0, 8'h00, 8'hfe, 0,  2,  8'h00, 0, 0, 8'h00, 0};
        vecs[9]  = '{4'd12, 1,  0, 8'h00, 8'hfe, 0, 128, 8'h80, 0, 0, 8'h00, 0};
        vecs[10] = '{4'd5,  0,  0, 8'h10, 8'hfe, 1,  8,  8'h00, 0, 0, 8'h00, 1};

        i_reset_n = 1'b0; i_start = 1'b0; i_lgblksz = 4'd0; i_fifo = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst ll_stb", 32'(o_ll_stb), 32'd0);
        check("rst ll_byte", 32'(o_ll_byte), 32'hff);
        check("rst write", 32'(o_write), 32'd0);
        check("rst addr", 32'(o_addr), 32'd0);
        check("rst data", o_data, 32'd0);
        check("rst flags", 32'({o_done, o_err, o_crcerr, o_timeout}), 32'd0);
        check("rst response", 32'(o_response), 32'd0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Directed table
        for (int v = 0; v < 11; v++) begin
            build_stim(vecs[v].nff, vecs[v].junk, vecs[v].tok, vecs[v].lg, 0, vecs[v].bad_crc);
            exp_words.delete();
            for (int w = 0; w < vecs[v].exp_nw; w++)
                exp_words.push_back({8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)});
`ifdef SPIRXDATA_CRC_EN
            e_crc = vecs[v].exp_crc_en;
`else
            e_crc = 0;
`endif
            run_xfer(vecs[v].lg, vecs[v].fifo, 0, got);
            compare_result($sformatf("vec%0d", v), vecs[v].exp_base, got, vecs[v].exp_err,
                           vecs[v].exp_to, e_crc, vecs[v].exp_resp);
        end

        // Randomised transfers against the stream model
        for (int t = 0; t < 30; t++) begin
            lg   = 4'($urandom_range(2, 6));
            fifo = 1'($urandom);
            spur_en = 1'($urandom);
            build_stim($urandom_range(0, 17),
                       ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(16, 253)),
                       ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 15)) : 8'hfe,
                       lg, 1, ($urandom_range(0, 2) == 0));
            model_run(lg);
            run_xfer(lg, fifo, 1'($urandom), got);
            compare_result($sformatf("rnd%0d", t), {fifo, 7'd0}, got, m_err, m_to, m_crc,
                           m_resp);
            check($sformatf("rnd%0d bytes_used", t), 32'(served), 32'(m_consumed));
        end
        spur_en = 0;

        // Reset in the middle of DATA after two writes
        build_stim(0, 8'h00, 8'hfe, 4'd4, 0, 0);
        @(negedge i_clk);
        i_lgblksz = 4'd4; i_fifo = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        nwr = 0;
        for (int c = 0; c < 2000 && nwr < 2; c++) begin
            @(negedge i_clk);
            if (o_write) nwr++;
        end
        check("midrst two_writes", 32'(nwr), 32'd2);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst ll_stb", 32'(o_ll_stb), 32'd0);
        check("midrst write", 32'(o_write), 32'd0);
        check("midrst addr", 32'(o_addr), 32'd0);
        check("midrst data", o_data, 32'd0);
        check("midrst flags", 32'({o_done, o_err, o_crcerr, o_timeout}), 32'd0);
        stim.delete();
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        spur_en = 1;
        nwr = 0; nstb = 0; nbusy = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_write) nwr++;
            if (o_ll_stb) nstb++;
            if (o_busy) nbusy++;
        end
        spur_en = 0;
        check("post_rst writes", 32'(nwr), 32'd0);
        check("post_rst ll_stb", 32'(nstb), 32'd0);
        check("post_rst busy", 32'(nbusy), 32'd0);
        build_stim(0, 8'h00, 8'hfe, 4'd3, 0, 0);
        exp_words.delete();
        exp_words.push_back(32'h01020304);
        exp_words.push_back(32'h05060708);
        run_xfer(4'd3, 1'b0, 0, got);
        compare_result("restart", 8'h00, got, 0, 0, 0, 8'h00);

        check("ll_request_overlap", 32'(stb_overlap), 32'd0);
        check("write_pulse_width", 32'(wr_dbl), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
